// File: rtl/wb_select_stage.sv
// wb_select_stage: registered write-back source selector with load-data
// alignment/extension and a valid/ready handshake on both sides.
module wb_select_stage #(
  parameter int W    = 32,
  parameter int NSRC = 4,
  parameter int RA   = 5,
  parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SW-1:0]   wb_sel,
  input  logic [NSRC*W-1:0] src_data,
  input  logic [RA-1:0]   rd_addr,
  input  logic            reg_write,
  input  logic [1:0]      ld_size,
  input  logic            ld_unsigned,
  input  logic [1:0]      byte_off,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    data_write,
  output logic [RA-1:0]   wb_addr,
  output logic            wb_en,
  output logic            misalign,
  output logic [31:0]     wb_count
);

  logic          accept;
  logic          sel_ok;
  logic          is_load;
  logic [W-1:0]  sel;
  logic [W-1:0]  shifted;
  logic [W-1:0]  nx_data;
  logic          nx_mis;
  logic          nx_en;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign sel_ok   = (32'(wb_sel) < 32'(NSRC));
  assign is_load  = (wb_sel == SW'(1));
  assign shifted  = sel >> {byte_off, 3'b000};

  // Source mux: one-hot compare so an out-of-range index never slices past src_data.
  always_comb begin
    sel = {W{1'b0}};
    for (int k = 0; k < NSRC; k++) begin
      if (wb_sel == SW'(k)) begin
        sel = src_data[k*W +: W];
      end else begin
        sel = sel;
      end
    end
  end

  // Next write data, misalignment flag and qualified enable for the offered op.
  always_comb begin
    nx_data = {W{1'b0}};
    nx_mis  = 1'b0;
    if (!sel_ok) begin
      nx_data = {W{1'b0}};
      nx_mis  = 1'b0;
    end else if (is_load) begin
      case (ld_size)
        2'd0: begin
          nx_data = ld_unsigned ? {{(W-8){1'b0}}, shifted[7:0]}
                                : {{(W-8){shifted[7]}}, shifted[7:0]};
          nx_mis  = 1'b0;
        end
        2'd1: begin
          nx_data = ld_unsigned ? {{(W-16){1'b0}}, shifted[15:0]}
                                : {{(W-16){shifted[15]}}, shifted[15:0]};
          nx_mis  = byte_off[0];
        end
        default: begin
          // Word loads are never shifted; a nonzero offset only flags misalignment.
          nx_data = sel;
          nx_mis  = (byte_off != 2'd0);
        end
      endcase
    end else begin
      nx_data = sel;
      nx_mis  = 1'b0;
    end
    nx_en = reg_write && (rd_addr != {RA{1'b0}}) && !nx_mis && sel_ok;
  end

  // Output register: flush drops, accept loads, retire without accept only clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_write <= {W{1'b0}};
      wb_addr    <= {RA{1'b0}};
      wb_en      <= 1'b0;
      misalign   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      wb_en     <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      data_write <= nx_data;
      wb_addr    <= rd_addr;
      wb_en      <= nx_en;
      misalign   <= nx_mis;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Completed-write counter; a held op dropped by flush does not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= 32'd0;
    end else if (out_valid && out_ready && wb_en && !flush) begin
      wb_count <= wb_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: scoreboard of expected write-backs.
module tb_wb_select_stage;

  localparam int W    = 32;
  localparam int NSRC = 5;
  localparam int RA   = 5;
  localparam int SW   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SW-1:0]    wb_sel = '0;
  logic [NSRC*W-1:0] src_data = '0;
  logic [RA-1:0]    rd_addr = '0;
  logic             reg_write = 1'b0;
  logic [1:0]       ld_size = 2'd0;
  logic             ld_unsigned = 1'b0;
  logic [1:0]       byte_off = 2'd0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     data_write;
  logic [RA-1:0]    wb_addr;
  logic             wb_en;
  logic             misalign;
  logic [31:0]      wb_count;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  logic        m_valid = 1'b0;
  logic        m_flushed = 1'b0;
  logic [31:0] m_count = 32'd0;
  int          checks = 0;
  int          errors = 0;

  wb_select_stage #(.W(W), .NSRC(NSRC), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .src_data(src_data), .rd_addr(rd_addr), .reg_write(reg_write),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .byte_off(byte_off),
    .out_valid(out_valid), .out_ready(out_ready), .data_write(data_write),
    .wb_addr(wb_addr), .wb_en(wb_en), .misalign(misalign), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result built from byte lanes rather than shifts.
  function automatic exp_t expect_of(input int s, input logic [31:0] v, input logic [4:0] rd,
                                     input logic rw, input logic [1:0] sz,
                                     input logic uns, input logic [1:0] off);
    exp_t e;
    logic [39:0] wide;
    logic [7:0]  b;
    logic [15:0] h;
    wide = {8'h00, v};
    b = wide[8*off +: 8];
    h = wide[8*off +: 16];
    e.addr = rd;
    e.mis  = 1'b0;
    e.data = 32'd0;
    if (s >= NSRC) e.data = 32'd0;
    else if (s != 1) e.data = v;
    else if (sz == 2'd0) e.data = uns ? {24'd0, b} : {{24{b[7]}}, b};
    else if (sz == 2'd1) begin
      e.data = uns ? {16'd0, h} : {{16{h[15]}}, h};
      e.mis  = (off == 2'd1) || (off == 2'd3);
    end else begin
      e.data = v;
      e.mis  = (off != 2'd0);
    end
    e.en = rw && (rd != 5'd0) && !e.mis && (s < NSRC);
    return e;
  endfunction

  task automatic tick();
    logic retire, acc;
    exp_t e;
    #1;
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    @(posedge clk);
    retire = m_valid && out_ready;
    acc    = in_valid && (!m_valid || out_ready) && !flush;
    if (flush) begin
      if (m_valid) void'(q.pop_front());
      m_valid   = 1'b0;
      m_flushed = 1'b1;
    end else begin
      if (retire) begin
        e = q.pop_front();
        if (e.en) m_count = m_count + 32'd1;
      end
      if (acc) begin
        q.push_back(expect_of(int'(wb_sel),
                    (int'(wb_sel) < NSRC) ? src_data[int'(wb_sel)*W +: W] : 32'd0,
                    rd_addr, reg_write, ld_size, ld_unsigned, byte_off));
        m_valid   = 1'b1;
        m_flushed = 1'b0;
      end else if (retire) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid && q.size() > 0) begin
      check_eq("data_write", {32'd0, data_write}, {32'd0, q[0].data});
      check_eq("wb_addr", {59'd0, wb_addr}, {59'd0, q[0].addr});
      check_eq("wb_en", {63'd0, wb_en}, {63'd0, q[0].en});
      check_eq("misalign", {63'd0, misalign}, {63'd0, q[0].mis});
    end else if (m_flushed) begin
      check_eq("wb_en_flushed", {63'd0, wb_en}, 64'd0);
    end
    check_eq("wb_count", {32'd0, wb_count}, {32'd0, m_count});
  endtask

  task automatic op(input int s, input logic [4:0] rd, input logic rw, input logic [1:0] sz,
                    input logic uns, input logic [1:0] off);
    in_valid    = 1'b1;
    wb_sel      = SW'(s);
    rd_addr     = rd;
    reg_write   = rw;
    ld_size     = sz;
    ld_unsigned = uns;
    byte_off    = off;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_data"}, {32'd0, data_write}, 64'd0);
    check_eq({tag, "_addr"}, {59'd0, wb_addr}, 64'd0);
    check_eq({tag, "_en"}, {63'd0, wb_en}, 64'd0);
    check_eq({tag, "_mis"}, {63'd0, misalign}, 64'd0);
    check_eq({tag, "_count"}, {32'd0, wb_count}, 64'd0);
  endtask

  initial begin
    src_data[0*W +: W] = 32'h1111_2222;
    src_data[1*W +: W] = 32'hAAAA_BBBB;
    src_data[2*W +: W] = 32'h0000_1004;
    src_data[3*W +: W] = 32'hFFFF_F800;
    src_data[4*W +: W] = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Plain source selection.
    op(0, 5'd5, 1'b1, 2'd2, 1'b0, 2'd0);
    op(1, 5'd6, 1'b1, 2'd2, 1'b0, 2'd0);
    op(2, 5'd7, 1'b1, 2'd0, 1'b0, 2'd3);
    op(4, 5'd8, 1'b1, 2'd2, 1'b1, 2'd1);

    // Load extension and alignment.
    src_data[1*W +: W] = 32'h8070_60F0;
    op(1, 5'd9, 1'b1, 2'd0, 1'b0, 2'd0);
    op(1, 5'd9, 1'b1, 2'd0, 1'b1, 2'd3);
    op(1, 5'd9, 1'b1, 2'd1, 1'b0, 2'd2);
    op(1, 5'd9, 1'b1, 2'd1, 1'b1, 2'd0);
    op(1, 5'd10, 1'b1, 2'd1, 1'b0, 2'd1);
    op(1, 5'd10, 1'b1, 2'd3, 1'b0, 2'd2);
    op(1, 5'd11, 1'b1, 2'd2, 1'b0, 2'd0);
    op(3, 5'd11, 1'b1, 2'd1, 1'b0, 2'd1);
    idle(1);

    // Backpressure: one op held, then back-to-back retire.
    out_ready = 1'b0;
    op(0, 5'd12, 1'b1, 2'd2, 1'b0, 2'd0);
    op(2, 5'd13, 1'b1, 2'd2, 1'b0, 2'd0);
    op(3, 5'd14, 1'b1, 2'd2, 1'b0, 2'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) op(i % NSRC, 5'(i + 16), 1'b1, 2'd2, 1'b0, 2'd0);

    // No-write cases still retire.
    op(0, 5'd0, 1'b1, 2'd2, 1'b0, 2'd0);
    op(5, 5'd3, 1'b1, 2'd2, 1'b0, 2'd0);
    op(7, 5'd3, 1'b1, 2'd0, 1'b0, 2'd0);
    op(2, 5'd3, 1'b0, 2'd2, 1'b0, 2'd0);
    idle(1);

    // Flush while holding, and flush beating an offered op.
    out_ready = 1'b0;
    op(0, 5'd4, 1'b1, 2'd2, 1'b0, 2'd0);
    flush = 1'b1;
    op(2, 5'd4, 1'b1, 2'd2, 1'b0, 2'd0);
    out_ready = 1'b1;
    op(3, 5'd4, 1'b1, 2'd2, 1'b0, 2'd0);
    flush = 1'b0;
    idle(2);

    // Counter wrap from all-ones.
    force dut.wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    m_count = 32'hFFFF_FFFF;
    op(0, 5'd1, 1'b1, 2'd2, 1'b0, 2'd0);
    idle(1);
    check_eq("wrap", {32'd0, wb_count}, 64'd0);

    // Asynchronous reset while an op is held.
    out_ready = 1'b0;
    op(4, 5'd2, 1'b1, 2'd2, 1'b0, 2'd0);
    op(4, 5'd2, 1'b1, 2'd2, 1'b0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    m_valid = 1'b0;
    m_flushed = 1'b0;
    m_count = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    op(1, 5'd31, 1'b1, 2'd2, 1'b0, 2'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
